core_mem: RTL and testbench
===========================

Name: core_mem

Overview:
- Memory-access pipeline stage: the consumer end of the EX_MEM interface. Registers EX_MEM, performs loads and stores on a 64-bit word-aligned data bus using a req/ack handshake, and produces MEM_WB for writeback.
- Asserts o_stall so the upstream EX stage holds EX_MEM stable until an access completes.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- XLEN, 64, data/address width; only 64 is supported.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_EX_MEM  in  EX_MEM_t  stage input.
  - Fields used: valid, PC, funct3, funct5, data, addr, rd, we, ld, st, csr, csr_data, csr_st, amo.
  - For stores, data is the store data.
  - For loads and stores, addr is the effective address.
- o_MEM_WB  out  MEM_WB_t  {valid, PC[63:0], rd[4:0], we, data[63:0], csr[11:0], csr_data[63:0], csr_st}.
- i_flush  in  1  squash current and in-flight results.
- o_stall  out  1  hold upstream (EX stage and earlier).
- o_mem_req  out  1  bus request; held until ack.
- o_mem_we  out  1  1 = write.
- o_mem_addr  out  64  word address, {addr[63:3],3'b000}.
- o_mem_be  out  8  byte enables.
- o_mem_wdata  out  64  write data, shifted to lane addr[2:0].
- i_mem_ack  in  1  single-cycle completion.
- i_mem_rdata  in  64  read data, valid with ack.
- o_misaligned  out  1  one-cycle pulse on a misaligned access.
- o_misaligned_addr  out  64  faulting address.

Behaviour:
- Reset (async, i_reset_n=0):
  - All o_MEM_WB fields 0.
  - o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_misaligned, o_misaligned_addr all 0.
  - FSM returns to IDLE. Reset mid-access abandons the bus transaction.
- FSM states: IDLE, ACCESS, AMO_WR (AMO_WR exists only with the optional feature).
- Let memop = i_EX_MEM.valid && (ld || st || amo).
- IDLE, non-memop:
  - Next edge: o_MEM_WB <= fields of i_EX_MEM, data = i_EX_MEM.data, valid = i_EX_MEM.valid.
  - Latency 1 cycle; o_stall = 0.
- IDLE, memop, aligned:
  - o_stall = 1 combinationally.
  - Next edge: o_mem_req=1, addr/we/be/wdata registered, FSM -> ACCESS, o_MEM_WB.valid <= 0.
- ACCESS:
  - Request outputs held stable while !i_mem_ack; o_stall = 1.
  - In the ack cycle o_stall = 0. Next edge: o_mem_req=0, o_MEM_WB written, FSM -> IDLE.
  - Load latency is therefore 2 cycles + bus wait.
- Alignment: legal if addr is a multiple of size (1/2/4/8 bytes by funct3[1:0]).
- Misaligned access:
  - No bus request.
  - Next edge: o_misaligned=1 for one cycle, o_misaligned_addr=addr, o_MEM_WB.valid=0.
  - o_stall = 0.
- Loads:
  - Byte lane = addr[2:0].
  - LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend; LD takes the full word.
- Stores:
  - be = size mask << addr[2:0]; wdata = data << (8*addr[2:0]).
  - o_MEM_WB.we forced 0.
- LR = load; SC = store whose rd result is 0 (always succeeds).
- Flush:
  - In IDLE: no request is issued; o_MEM_WB cleared (valid=0) at the next edge.
  - In ACCESS: the bus transaction runs to ack (a write cannot be aborted), the result is discarded, and o_MEM_WB.valid stays 0.
  - o_stall follows the ack as normal.
- Back-to-back memops: the second is evaluated in IDLE on the cycle after the first completes. No bubble is added beyond the request register.

Optional Feature:
- WIV_MEM_AMO_EN defined, AMO sequence:
  - amo=1 (except LR/SC): ACCESS performs the read; on ack FSM -> AMO_WR and the old value is latched.
  - AMO_WR writes f(old, data) with the same be; o_stall stays 1 until the write ack.
  - o_MEM_WB.data = old value (sign-extended for .W).
- f by funct5: SWAP 00001, ADD 00000, XOR 00100, AND 01100, OR 01000, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
- .W (funct3=010) operates on 32 bits.
- WIV_MEM_AMO_EN undefined: amo ops other than LR/SC produce o_MEM_WB.valid=0, no bus request and no stall. AMO_WR is absent.

Test Plan:
- ALU pass-through: EX_MEM {valid=1, data=0x1234, rd=5, we=1, ld=st=0} -> next cycle MEM_WB {valid=1, data=0x1234, rd=5}; o_stall never high.
- LB sign extension: addr=0x1003, funct3=000, ack after 3 wait cycles, rdata=0x00000000_80000000 -> o_mem_addr=0x1000, be=0x08, MEM_WB.data=0xFFFFFFFFFFFFFF80; o_stall high exactly until the ack cycle.
- SH: addr=0x2006, data=0xBEEF -> be=0xC0, wdata=0xBEEF000000000000, we=1, MEM_WB.we=0.
- Misaligned LW at 0x3002 -> o_misaligned one cycle with addr 0x3002, no o_mem_req, MEM_WB.valid=0.
- Flush during ACCESS of SD, ack two cycles later -> write still completes with be=0xFF, MEM_WB.valid=0; reset asserted mid-ACCESS -> o_mem_req drops immediately, FSM in IDLE.
- (WIV_MEM_AMO_EN) AMOADD.D addr=0x4000, data=5, read ack rdata=10 -> write of 15 with be=0xFF, MEM_WB.data=10.

Source files
------------

// File: rtl/core_mem.sv
// core_mem: memory-access stage turning EX_MEM into req/ack bus accesses and MEM_WB results.
// Define WIV_MEM_AMO_EN to add the AMO read-modify-write sequence (AMO_WR state).
package core_mem_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] PC;
    logic [2:0]  funct3;
    logic [4:0]  funct5;
    logic [63:0] data;
    logic [63:0] addr;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic        st;
    logic [11:0] csr;
    logic [63:0] csr_data;
    logic        csr_st;
    logic        amo;
  } EX_MEM_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] PC;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic [11:0] csr;
    logic [63:0] csr_data;
    logic        csr_st;
  } MEM_WB_t;
endpackage

module core_mem
  import core_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  EX_MEM_t         i_EX_MEM,
  output MEM_WB_t         o_MEM_WB,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [7:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_misaligned,
  output logic [XLEN-1:0] o_misaligned_addr
);
`ifdef WIV_MEM_AMO_EN
  typedef enum logic [1:0] {IDLE, ACCESS, AMO_WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS} state_t;
`endif
  state_t state;
  MEM_WB_t pass_wb, pend;
  logic lr, sc, rmw, memop, mis, go, fault, flushed, req_load;
  logic [2:0] req_f3, req_off;
  logic [7:0] size_mask;

  function automatic logic [63:0] ext(logic [63:0] w, logic [2:0] f3, logic [2:0] off);
    logic [63:0] s;
    s = w >> {off, 3'b000};
    return f3[1:0] == 2'd0 ? {{56{s[7] & !f3[2]}}, s[7:0]} :
           f3[1:0] == 2'd1 ? {{48{s[15] & !f3[2]}}, s[15:0]} :
           f3[1:0] == 2'd2 ? {{32{s[31] & !f3[2]}}, s[31:0]} : s;
  endfunction

  assign lr = i_EX_MEM.amo && i_EX_MEM.funct5 == 5'b00010;
  assign sc = i_EX_MEM.amo && i_EX_MEM.funct5 == 5'b00011;
  assign rmw = i_EX_MEM.amo && !lr && !sc;
  assign memop = i_EX_MEM.valid && (i_EX_MEM.ld || i_EX_MEM.st || i_EX_MEM.amo);
  assign size_mask = i_EX_MEM.funct3[1:0] == 2'd0 ? 8'h01 :
                     i_EX_MEM.funct3[1:0] == 2'd1 ? 8'h03 :
                     i_EX_MEM.funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
  assign mis = |(i_EX_MEM.addr[2:0] & {&i_EX_MEM.funct3[1:0], i_EX_MEM.funct3[1], |i_EX_MEM.funct3[1:0]});
  assign fault = memop && mis && !i_flush;
  // one struct serves both the pass-through result and the pending memop result
  assign pass_wb = '{valid: i_EX_MEM.valid && !memop, PC: i_EX_MEM.PC, rd: i_EX_MEM.rd,
                     we: i_EX_MEM.we && !i_EX_MEM.st, data: sc ? '0 : i_EX_MEM.data,
                     csr: i_EX_MEM.csr, csr_data: i_EX_MEM.csr_data, csr_st: i_EX_MEM.csr_st};

`ifdef WIV_MEM_AMO_EN
  logic req_rmw;
  logic [4:0] req_f5;
  logic [63:0] old, old_v, src;

  function automatic logic [63:0] amo_f(logic [4:0] f5, logic [63:0] a, logic [63:0] b);
    logic lt, ltu;
    lt = $signed(a) < $signed(b);
    ltu = a < b;
    return f5 == 5'b00001 ? b : f5 == 5'b00000 ? a + b : f5 == 5'b00100 ? a ^ b :
           f5 == 5'b01100 ? a & b : f5 == 5'b01000 ? a | b : f5 == 5'b10000 ? (lt ? a : b) :
           f5 == 5'b10100 ? (lt ? b : a) : f5 == 5'b11000 ? (ltu ? a : b) : (ltu ? b : a);
  endfunction

  assign old_v = ext(i_mem_rdata, req_f3, req_off);
  assign src = req_f3[0] ? pend.data : {{32{pend.data[31]}}, pend.data[31:0]};
  assign go = memop && !mis && !i_flush;
  assign o_stall = state == IDLE ? go : !(i_mem_ack && (state == AMO_WR || !req_rmw));
`else
  assign go = memop && !mis && !i_flush && !rmw;
  assign o_stall = state == IDLE ? go : !i_mem_ack;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      o_MEM_WB <= '0;
      pend <= '0;
      flushed <= 1'b0;
      req_load <= 1'b0;
      req_f3 <= '0;
      req_off <= '0;
      o_mem_req <= 1'b0;
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_be <= '0;
      o_mem_wdata <= '0;
      o_misaligned <= 1'b0;
      o_misaligned_addr <= '0;
`ifdef WIV_MEM_AMO_EN
      req_rmw <= 1'b0;
      req_f5 <= '0;
      old <= '0;
`endif
    end else begin
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          o_MEM_WB <= i_flush ? '0 : pass_wb;
          o_misaligned <= fault;
          if (fault) o_misaligned_addr <= i_EX_MEM.addr;
          if (go) begin
            state <= ACCESS;
            pend <= pass_wb;
            flushed <= 1'b0;
            req_load <= i_EX_MEM.ld || lr;
            req_f3 <= i_EX_MEM.funct3;
            req_off <= i_EX_MEM.addr[2:0];
            o_mem_req <= 1'b1;
            o_mem_we <= i_EX_MEM.st || sc;
            o_mem_addr <= {i_EX_MEM.addr[XLEN-1:3], 3'b000};
            o_mem_be <= size_mask << i_EX_MEM.addr[2:0];
            o_mem_wdata <= i_EX_MEM.data << {i_EX_MEM.addr[2:0], 3'b000};
`ifdef WIV_MEM_AMO_EN
            req_rmw <= rmw;
            req_f5 <= i_EX_MEM.funct5;
`endif
          end
        end
        ACCESS: begin
          if (i_flush) flushed <= 1'b1;
`ifdef WIV_MEM_AMO_EN
          if (i_mem_ack && req_rmw) begin
            state <= AMO_WR;
            old <= old_v;
            o_mem_we <= 1'b1;
            o_mem_wdata <= amo_f(req_f5, old_v, src) << {req_off, 3'b000};
          end else
`endif
          if (i_mem_ack) begin
            state <= IDLE;
            o_mem_req <= 1'b0;
            o_MEM_WB <= pend;
            o_MEM_WB.valid <= !flushed && !i_flush;
            if (req_load) o_MEM_WB.data <= ext(i_mem_rdata, req_f3, req_off);
          end
        end
`ifdef WIV_MEM_AMO_EN
        AMO_WR: begin
          if (i_flush) flushed <= 1'b1;
          if (i_mem_ack) begin
            state <= IDLE;
            o_mem_req <= 1'b0;
            o_MEM_WB <= pend;
            o_MEM_WB.valid <= !flushed && !i_flush;
            o_MEM_WB.data <= old;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_core_mem.sv
// tb_core_mem: directed bench for core_mem with an arithmetic load/store model and a per-cycle compare process.
module tb_core_mem;
  import core_mem_pkg::*;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic        chk_data;
  } wb_exp_t;

  logic clk = 1'b0, i_reset_n = 1'b0, i_flush = 1'b0, i_mem_ack = 1'b0;
  logic [63:0] i_mem_rdata = '0;
  EX_MEM_t i_EX_MEM = '0;
  MEM_WB_t o_MEM_WB;
  logic o_stall, o_mem_req, o_mem_we, o_misaligned;
  logic [63:0] o_mem_addr, o_mem_wdata, o_misaligned_addr;
  logic [7:0] o_mem_be;

  int n_vec = 0, n_bad = 0, ack_wait = 0, cnt = 0, req_cycles = 0, wr_cnt = 0;
  logic [63:0] rdata_v = '0, exp_addr = '0, exp_wdata = '0, ack_addr = '0, ack_wdata = '0;
  logic [7:0] exp_be = '0, ack_be = '0;
  logic exp_we = 1'b0, exp_amo = 1'b0, ack_we = 1'b0;
  wb_exp_t wb_q[$];

  core_mem dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_EX_MEM(i_EX_MEM), .o_MEM_WB(o_MEM_WB),
    .i_flush(i_flush), .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_misaligned(o_misaligned), .o_misaligned_addr(o_misaligned_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [63:0] m_load(logic [63:0] w, logic [63:0] a, int f3);
    int n;
    logic [63:0] v, m;
    n = 1 << (f3 % 4);
    v = w >> (8 * (a % 8));
    if (n < 8) begin
      m = (64'd1 << (8 * n)) - 1;
      v = v & m;
      if (f3 < 4 && v[8*n-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic set_req(input logic [63:0] a, input int f3, input logic we, input logic [63:0] d, input logic amo);
    exp_addr = a - (a % 8);
    exp_be = 8'(((1 << (1 << (f3 % 4))) - 1) << (a % 8));
    exp_we = we;
    exp_wdata = d << (8 * (a % 8));
    exp_amo = amo;
  endtask

  function automatic EX_MEM_t mk(logic [63:0] pc, logic [2:0] f3, logic [4:0] f5, logic [63:0] d,
                                 logic [63:0] a, logic [4:0] rd, logic we, logic ld, logic st, logic amo);
    EX_MEM_t e;
    e = '0;
    e.valid = 1'b1; e.PC = pc; e.funct3 = f3; e.funct5 = f5; e.data = d; e.addr = a;
    e.rd = rd; e.we = we; e.ld = ld; e.st = st; e.amo = amo;
    e.csr = pc[11:0]; e.csr_data = ~pc;
    return e;
  endfunction

  task automatic push(input EX_MEM_t e, input logic we, input logic [63:0] d, input logic cd);
    wb_q.push_back('{pc: e.PC, rd: e.rd, we: we, data: d, chk_data: cd});
  endtask

  // present an instruction and hold it like the EX stage does while o_stall is high
  task automatic issue(input EX_MEM_t e, output int stalls);
    i_EX_MEM = e;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!o_stall) break;
      stalls++;
      if (stalls > 60) begin
        chk("stall_timeout", 64'(o_stall), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    i_EX_MEM = '0;
  endtask

  // bus slave: acks after ack_wait idle request cycles and logs what it accepted
  initial forever begin
    @(posedge clk); #1;
    if (i_mem_ack || !o_mem_req || !i_reset_n) begin
      i_mem_ack = 1'b0;
      cnt = 0;
    end else if (cnt == ack_wait) begin
      i_mem_ack = 1'b1;
      i_mem_rdata = rdata_v;
      ack_addr = o_mem_addr; ack_be = o_mem_be; ack_we = o_mem_we; ack_wdata = o_mem_wdata;
      if (o_mem_we) wr_cnt++;
    end else cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (i_reset_n) begin
      if (o_mem_req) begin
        req_cycles++;
        chk("req_addr", o_mem_addr, exp_addr);
        chk("req_be", 64'(o_mem_be), 64'(exp_be));
        if (!exp_amo) chk("req_we", 64'(o_mem_we), 64'(exp_we));
        if (o_mem_we) chk("req_wdata", o_mem_wdata, exp_wdata);
      end
      if (o_MEM_WB.valid) begin
        if (wb_q.size() == 0) chk("wb_unexpected_valid", 64'(o_MEM_WB.valid), 64'd0);
        else begin
          wb_exp_t x;
          x = wb_q.pop_front();
          chk("wb_pc", o_MEM_WB.PC, x.pc);
          chk("wb_rd", 64'(o_MEM_WB.rd), 64'(x.rd));
          chk("wb_we", 64'(o_MEM_WB.we), 64'(x.we));
          chk("wb_csr", 64'(o_MEM_WB.csr), 64'(x.pc[11:0]));
          if (x.chk_data) chk("wb_data", o_MEM_WB.data, x.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [63:0] ld_a  [5] = '{64'h1008, 64'h100E, 64'h1004, 64'h1004, 64'h1002};
  int          ld_f3 [5] = '{3, 5, 2, 6, 1};
  logic [63:0] ld_rd [5] = '{64'h0123_4567_89AB_CDEF, 64'h8765_0000_0000_0000,
                             64'hDEAD_BEEF_0000_0000, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_7FFF_0000};

  initial begin
    EX_MEM_t e;
    int st, rq;
    #12;
    chk("rst_wb", 64'(o_MEM_WB != '0), 64'd0);
    chk("rst_req", 64'(o_mem_req), 64'd0);
    chk("rst_we", 64'(o_mem_we), 64'd0);
    chk("rst_be", 64'(o_mem_be), 64'd0);
    chk("rst_addr", o_mem_addr, 64'd0);
    chk("rst_wdata", o_mem_wdata, 64'd0);
    chk("rst_mis", 64'(o_misaligned), 64'd0);
    chk("rst_mis_addr", o_misaligned_addr, 64'd0);
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    @(posedge clk); #1;

    e = mk(64'h100, 3'd0, 5'd0, 64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    push(e, 1'b1, 64'h1234, 1'b1);
    issue(e, st);
    chk("alu_stall", 64'(st), 64'd0);
    chk("alu_data_lit", o_MEM_WB.data, 64'h1234);
    chk("alu_rd_lit", 64'(o_MEM_WB.rd), 64'd5);

    ack_wait = 3; rdata_v = 64'h0000_0000_8000_0000;
    set_req(64'h1003, 0, 1'b0, 64'd0, 1'b0);
    e = mk(64'h104, 3'b000, 5'd0, 64'd0, 64'h1003, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    push(e, 1'b1, m_load(rdata_v, 64'h1003, 0), 1'b1);
    issue(e, st);
    chk("lb_stall", 64'(st), 64'd4);
    chk("lb_addr_lit", ack_addr, 64'h1000);
    chk("lb_be_lit", 64'(ack_be), 64'h08);
    @(negedge clk);
    chk("lb_data_lit", o_MEM_WB.data, 64'hFFFF_FFFF_FFFF_FF80);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      ack_wait = i % 3; rdata_v = ld_rd[i];
      set_req(ld_a[i], ld_f3[i], 1'b0, 64'd0, 1'b0);
      e = mk(64'h200 + 64'(4 * i), 3'(ld_f3[i]), 5'd0, 64'd0, ld_a[i], 5'(7 + i), 1'b1, 1'b1, 1'b0, 1'b0);
      push(e, 1'b1, m_load(rdata_v, ld_a[i], ld_f3[i]), 1'b1);
      issue(e, st);
      chk("ld_stall", 64'(st), 64'(1 + ack_wait));
    end

    ack_wait = 1; rdata_v = 64'h0011_2233_4455_6677;
    set_req(64'h1018, 3, 1'b0, 64'd0, 1'b0);
    e = mk(64'h230, 3'b011, 5'b00010, 64'd0, 64'h1018, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    push(e, 1'b1, rdata_v, 1'b1);
    issue(e, st);

    ack_wait = 0;
    set_req(64'h2006, 1, 1'b1, 64'hBEEF, 1'b0);
    e = mk(64'h300, 3'b001, 5'd0, 64'hBEEF, 64'h2006, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    push(e, 1'b0, 64'd0, 1'b0);
    issue(e, st);
    chk("sh_be_lit", 64'(ack_be), 64'hC0);
    chk("sh_wdata_lit", ack_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_we_lit", 64'(ack_we), 64'd1);
    @(negedge clk);
    chk("sh_wb_we", 64'(o_MEM_WB.we), 64'd0);
    @(posedge clk); #1;

    rq = req_cycles;
    e = mk(64'h400, 3'b010, 5'd0, 64'd0, 64'h3002, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(e, st);
    chk("mis_stall", 64'(st), 64'd0);
    chk("mis_pulse", 64'(o_misaligned), 64'd1);
    chk("mis_addr", o_misaligned_addr, 64'h3002);
    chk("mis_wb_valid", 64'(o_MEM_WB.valid), 64'd0);
    @(posedge clk); #1;
    chk("mis_pulse_end", 64'(o_misaligned), 64'd0);
    chk("mis_no_req", 64'(req_cycles), 64'(rq));

    i_flush = 1'b1;
    e = mk(64'h500, 3'd0, 5'd0, 64'h77, 64'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(e, st);
    i_flush = 1'b0;
    chk("flush_idle_valid", 64'(o_MEM_WB.valid), 64'd0);

    ack_wait = 2; rq = wr_cnt;
    set_req(64'h5008, 3, 1'b1, 64'h1122_3344_5566_7788, 1'b0);
    i_EX_MEM = mk(64'h600, 3'b011, 5'd0, 64'h1122_3344_5566_7788, 64'h5008, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    i_flush = 1'b1; i_EX_MEM = '0;
    @(posedge clk); #1;
    i_flush = 1'b0;
    for (int k = 0; k < 20 && o_mem_req; k++) @(posedge clk); #1;
    chk("flush_sd_req_done", 64'(o_mem_req), 64'd0);
    chk("flush_sd_written", 64'(wr_cnt), 64'(rq + 1));
    chk("flush_sd_be", 64'(ack_be), 64'hFF);
    chk("flush_sd_valid", 64'(o_MEM_WB.valid), 64'd0);

    ack_wait = 20;
    set_req(64'h6000, 3, 1'b0, 64'd0, 1'b0);
    i_EX_MEM = mk(64'h700, 3'b011, 5'd0, 64'd0, 64'h6000, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    i_EX_MEM = '0;
    @(negedge clk);
    chk("rst_mid_req_before", 64'(o_mem_req), 64'd1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("rst_mid_req", 64'(o_mem_req), 64'd0);
    chk("rst_mid_stall", 64'(o_stall), 64'd0);
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    e = mk(64'h704, 3'd0, 5'd0, 64'h55, 64'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    push(e, 1'b1, 64'h55, 1'b1);
    issue(e, st);
    chk("rst_mid_idle_stall", 64'(st), 64'd0);

`ifdef WIV_MEM_AMO_EN
    ack_wait = 0; rdata_v = 64'd10; rq = wr_cnt;
    set_req(64'h4000, 3, 1'b0, 64'd0, 1'b1);
    exp_wdata = 64'd15;
    e = mk(64'h800, 3'b011, 5'b00000, 64'd5, 64'h4000, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
    push(e, 1'b1, 64'd10, 1'b1);
    issue(e, st);
    chk("amo_stall", 64'(st), 64'd3);
    chk("amo_wdata_lit", ack_wdata, 64'd15);
    chk("amo_be_lit", 64'(ack_be), 64'hFF);
    chk("amo_written", 64'(wr_cnt), 64'(rq + 1));
    @(negedge clk);
    chk("amo_wb_data_lit", o_MEM_WB.data, 64'd10);
    @(posedge clk); #1;
`else
    rq = req_cycles;
    e = mk(64'h800, 3'b011, 5'b00000, 64'd5, 64'h4000, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(e, st);
    chk("amo_off_stall", 64'(st), 64'd0);
    chk("amo_off_valid", 64'(o_MEM_WB.valid), 64'd0);
    @(posedge clk); #1;
    chk("amo_off_no_req", 64'(req_cycles), 64'(rq));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("wb_pending", 64'(wb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
